miinst_issue_queue: RTL and testbench
=====================================

Name: miinst_issue_queue

Overview:
- Sits between the fetch/decode phase and the execute stage. Consumes the per-instruction micro-instruction bundle of `MQ_N miinst_t slots that decode produces.
- Discards NOP slots and compacts the remaining slots, preserving slot order, into a circular buffer.
- Issues the buffered micro-instructions to execute one per cycle under a valid/ready handshake.
- Provides backpressure to decode and supports a pipeline flush for redirects (jumps, ret).

Parameters:
- DEPTH, 16, number of queue entries. Must be a power of two and >= `MQ_N.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy counter.

Ports:
- clk  in  1  system clock.
- rstn  in  1  synchronous active-low reset.
- flush  in  1  discard all queued and incoming micro-instructions this cycle.
- bundle_valid  in  1  decode presents a complete bundle.
- bundle_miinst  in  miinst_t[`MQ_N]  micro-instruction slots, slot 0 oldest.
- bundle_ready  out  1  queue can accept a full bundle.
- issue_valid  out  1  issue_miinst holds a valid micro-instruction.
- issue_miinst  out  miinst_t  head-of-queue micro-instruction.
- issue_ready  in  1  execute accepts issue_miinst this cycle.
- count  out  CNT_W  current occupancy.
- empty  out  1  count==0.

Behaviour:
- Reset is synchronous on rstn==0 at a clk edge. Reset and flush have the same effect:
  - head, tail and count go to 0.
  - issue_valid=0, empty=1.
  - bundle_ready=1.
  - issue_miinst value is don't-care while issue_valid=0. Memory contents are not cleared.
- A slot is a NOP when its op==MIOP_NOP. NOP slots are never stored.
- The accept condition is bundle_valid && bundle_ready && !flush.
  - On accept, the non-NOP slots are written to tail, tail+1, … in ascending slot index.
  - tail advances by the number of non-NOP slots, k (0..`MQ_N), modulo DEPTH.
  - A bundle with all slots NOP is accepted and stores nothing (k=0).
- bundle_ready = (DEPTH - count) >= `MQ_N.
  - It is computed from registered count only. It does not credit a same-cycle pop.
  - Combinational from state only; it never depends on bundle_valid.
- issue_valid = (count != 0).
- issue_miinst = mem[head]. It is a direct read of registered state, with zero latency from the entry becoming head.
- The pop condition is issue_valid && issue_ready && !flush. On pop, head advances by 1 modulo DEPTH.
- A stored entry is visible at issue the cycle after the write, so push-to-issue latency is 1 clk.
- Simultaneous push and pop in the same cycle:
  - next count = count + k - 1.
  - The entry popped is the old head, never an entry written the same cycle.
- Flush has priority over push and pop:
  - A bundle presented with flush is dropped, and bundle_ready is not consulted.
  - A pop is not counted during flush, even when issue_ready=1.
- Pointer wrap: head and tail wrap DEPTH-1 -> 0. A bundle straddling the wrap writes its entries across mem[DEPTH-1] and mem[0] in order.
- Invariant: 0 <= count <= DEPTH. count is never exceeded because bundle_ready guarantees room for `MQ_N entries.
- The stored miinst_t (op, d, s, bmd, pc, etc.) is passed through bit-exact; no fields are modified.
- bundle_miinst is not sampled when bundle_valid=0.
- An issue_ready pulse while empty has no effect.

Test Plan (`MQ_N=4, DEPTH=8):
- Reset, then a PUSH bundle {ADDI, STORE, NOP, NOP} with issue_ready=0:
  - count=2, bundle_ready=1.
  - Then issue_ready=1 pops ADDI, then STORE on consecutive cycles.
  - count returns to 0, empty=1.
- Three back-to-back 3-uop RET bundles (LOAD, ADDI, JR) with issue_ready=0:
  - After 2 bundles count=6 and bundle_ready=0.
  - The third bundle is held by decode.
  - One pop gives count=5, still not ready. A second pop gives count=4, ready=1, and the third bundle is accepted.
- Wrap-around: fill to tail=6, then push the 3-uop bundle {A,B,C}:
  - The entries land at mem[6], mem[7], mem[0].
  - They issue in order A, B, C.
- Same-cycle push of a 2-uop bundle and pop at count=3:
  - next count=4.
  - The issued uop is the old head, and order is preserved.
- Flush with count=5 while bundle_valid=1 and issue_ready=1:
  - The next cycle has count=0, issue_valid=0, and the bundle is dropped.
  - A subsequent bundle issues normally from head=0.
- An all-NOP bundle followed by a JMP bundle:
  - count stays 0, then becomes 1.
  - issue_miinst.op=MIOP_J and its pc matches the input.
- A rstn=0 pulse while count=7 and mid-handshake clears state as specified for flush.

Source files
------------

// File: rtl/miinst_issue_queue_if.sv
// Micro-instruction types shared by decode, the issue queue and execute,
// plus the handshake interface between decode, the queue and execute.

`ifndef MQ_N
`define MQ_N 4
`endif

package miinst_pkg;

    typedef enum logic [3:0] {
        MIOP_NOP   = 4'd0,
        MIOP_ADDI  = 4'd1,
        MIOP_LOAD  = 4'd2,
        MIOP_STORE = 4'd3,
        MIOP_J     = 4'd4,
        MIOP_JR    = 4'd5
    } miop_e;

    typedef struct packed {
        miop_e       op;
        logic [4:0]  d;
        logic [4:0]  s;
        logic [3:0]  bmd;
        logic [31:0] pc;
    } miinst_t;

endpackage

interface miinst_issue_queue_if
    import miinst_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) ();

    logic                       flush;
    logic                       bundle_valid;
    miinst_t [`MQ_N-1:0]        bundle_miinst;
    logic                       bundle_ready;
    logic                       issue_valid;
    miinst_t                    issue_miinst;
    logic                       issue_ready;
    logic [CNT_W-1:0]           count;
    logic                       empty;

    // Decode/execute side: drives bundles, flush and issue_ready.
    modport master (
        output flush, bundle_valid, bundle_miinst, issue_ready,
        input  bundle_ready, issue_valid, issue_miinst, count, empty
    );

    // Queue side.
    modport slave (
        input  flush, bundle_valid, bundle_miinst, issue_ready,
        output bundle_ready, issue_valid, issue_miinst, count, empty
    );

endinterface

// File: rtl/miinst_issue_queue.sv
// Micro-instruction issue queue: drops NOP slots from each decode bundle,
// compacts the rest in slot order into a circular buffer and issues them
// to execute one per cycle. Flush and reset empty the queue.

module miinst_issue_queue
    import miinst_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    miinst_issue_queue_if.slave  q
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int MQ_N  = `MQ_N;
    // Highest occupancy that still leaves room for a full bundle.
    localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - MQ_N);

    miinst_t            mem [DEPTH];
    logic [PTR_W-1:0]   head_reg;
    logic [PTR_W-1:0]   tail_reg;
    logic [CNT_W-1:0]   count_reg;

    logic [MQ_N-1:0]    live;
    logic [CNT_W-1:0]   slot_off [MQ_N+1];
    logic [CNT_W-1:0]   off_acc;
    logic [PTR_W-1:0]   wr_addr [MQ_N];
    logic [CNT_W-1:0]   push_cnt;
    logic               bundle_ready;
    logic               issue_valid;
    logic               accept;
    logic               pop;

    // Per-slot liveness and write address (tail plus live slots before it).
    generate
        for (genvar gi = 0; gi < MQ_N; gi++) begin : g_slot
            assign live[gi]    = (q.bundle_miinst[gi].op != MIOP_NOP);
            assign wr_addr[gi] = tail_reg + slot_off[gi][PTR_W-1:0];
        end
    endgenerate

    // Running count of live slots preceding each slot; last entry is k.
    always_comb begin
        off_acc = '0;
        for (int i = 0; i < MQ_N; i++) begin
            slot_off[i] = off_acc;
            off_acc     = off_acc + CNT_W'(live[i]);
        end
        slot_off[MQ_N] = off_acc;
    end

    assign push_cnt     = slot_off[MQ_N];
    assign bundle_ready = (count_reg <= READY_MAX);
    assign issue_valid  = (count_reg != '0);
    assign accept       = q.bundle_valid && bundle_ready && !q.flush;
    assign pop          = issue_valid && q.issue_ready && !q.flush;

    assign q.bundle_ready = bundle_ready;
    assign q.issue_valid  = issue_valid;
    assign q.issue_miinst = mem[head_reg];
    assign q.count        = count_reg;
    assign q.empty        = (count_reg == '0);

    // Storage write: live slots land at consecutive entries from tail.
    // Contents are deliberately left untouched by reset and flush.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < MQ_N; i++) begin
                if (live[i]) begin
                    mem[wr_addr[i]] <= q.bundle_miinst[i];
                end
            end
        end
    end

    // Pointer and occupancy update; flush behaves exactly like reset.
    always_ff @(posedge clk) begin
        if (!rstn || q.flush) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (accept) begin
                tail_reg <= tail_reg + push_cnt[PTR_W-1:0];
            end
            if (pop) begin
                head_reg <= head_reg + PTR_W'(1);
            end
            count_reg <= count_reg + (accept ? push_cnt : '0) - CNT_W'(pop);
        end
    end

endmodule

// File: tb/tb_miinst_issue_queue.sv
// Directed bench for miinst_issue_queue (MQ_N=4, DEPTH=8). Expected issue
// order goes into a scoreboard queue; a monitor compares every handshake.

`timescale 1ns/1ps

module tb_miinst_issue_queue;
    import miinst_pkg::*;

    localparam int DEPTH = 8;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef miinst_t [`MQ_N-1:0] bundle_t;

    logic clk = 1'b0;
    logic rstn;
    int   total = 0;
    int   bad   = 0;
    miinst_t exp_q [$];

    miinst_issue_queue_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) q ();

    miinst_issue_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk  (clk),
        .rstn (rstn),
        .q    (q)
    );

    always #5 clk = ~clk;

    function automatic miinst_t mk(miop_e op, logic [31:0] pc);
        miinst_t m;
        m.op  = op;
        m.d   = pc[6:2];
        m.s   = pc[11:7];
        m.bmd = pc[3:0] ^ 4'h5;
        m.pc  = pc;
        return m;
    endfunction

    function automatic bundle_t bun(miinst_t s0, miinst_t s1, miinst_t s2, miinst_t s3);
        bundle_t b;
        b[0] = s0;
        b[1] = s1;
        b[2] = s2;
        b[3] = s3;
        return b;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted issue must match the next expected uop.
    initial begin
        miinst_t e;
        forever begin
            @(negedge clk);
            if (rstn && q.issue_valid && q.issue_ready && !q.flush) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL issue_unexpected: got %0h want none", q.issue_miinst);
                end else begin
                    e = exp_q.pop_front();
                    chk("issue_uop", 64'(q.issue_miinst), 64'(e));
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        miinst_t nop, a, b, c, x;
        miinst_t r1l, r1a, r1j, r2l, r2a, r2j, r3l, r3a, r3j;
        nop = mk(MIOP_NOP, 32'h0);

        rstn            = 1'b0;
        q.flush         = 1'b0;
        q.bundle_valid  = 1'b0;
        q.bundle_miinst = '0;
        q.issue_ready   = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        chk("rst_count", 64'(q.count), 0);
        chk("rst_empty", 64'(q.empty), 1);
        chk("rst_issue_valid", 64'(q.issue_valid), 0);
        chk("rst_bundle_ready", 64'(q.bundle_ready), 1);

        // Basic push of two live slots, then pop both.
        a = mk(MIOP_ADDI, 32'h100);
        b = mk(MIOP_STORE, 32'h104);
        exp_q.push_back(a);
        exp_q.push_back(b);
        q.bundle_miinst = bun(a, b, nop, nop);
        q.bundle_valid  = 1'b1;
        tick();
        q.bundle_valid = 1'b0;
        chk("t1_count", 64'(q.count), 2);
        chk("t1_ready", 64'(q.bundle_ready), 1);
        q.issue_ready = 1'b1;
        tick();
        chk("t1_count_pop1", 64'(q.count), 1);
        tick();
        q.issue_ready = 1'b0;
        chk("t1_count_pop2", 64'(q.count), 0);
        chk("t1_empty", 64'(q.empty), 1);

        // Backpressure with three 3-uop RET bundles.
        r1l = mk(MIOP_LOAD, 32'h200); r1a = mk(MIOP_ADDI, 32'h204); r1j = mk(MIOP_JR, 32'h208);
        r2l = mk(MIOP_LOAD, 32'h300); r2a = mk(MIOP_ADDI, 32'h304); r2j = mk(MIOP_JR, 32'h308);
        r3l = mk(MIOP_LOAD, 32'h400); r3a = mk(MIOP_ADDI, 32'h404); r3j = mk(MIOP_JR, 32'h408);
        exp_q.push_back(r1l); exp_q.push_back(r1a); exp_q.push_back(r1j);
        exp_q.push_back(r2l); exp_q.push_back(r2a); exp_q.push_back(r2j);
        exp_q.push_back(r3l); exp_q.push_back(r3a); exp_q.push_back(r3j);
        q.bundle_valid  = 1'b1;
        q.bundle_miinst = bun(r1l, r1a, r1j, nop);
        tick();
        q.bundle_miinst = bun(r2l, r2a, r2j, nop);
        tick();
        chk("t2_count6", 64'(q.count), 6);
        chk("t2_ready6", 64'(q.bundle_ready), 0);
        q.bundle_miinst = bun(r3l, r3a, r3j, nop);
        tick();
        chk("t2_held_count", 64'(q.count), 6);
        q.issue_ready = 1'b1;
        tick();
        chk("t2_count5", 64'(q.count), 5);
        chk("t2_ready5", 64'(q.bundle_ready), 0);
        tick();
        chk("t2_count4", 64'(q.count), 4);
        chk("t2_ready4", 64'(q.bundle_ready), 1);
        q.issue_ready = 1'b0;
        tick();
        q.bundle_valid = 1'b0;
        chk("t2_count7", 64'(q.count), 7);
        q.issue_ready = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        q.issue_ready = 1'b0;
        chk("t2_drained", 64'(q.count), 0);

        // Wrap-around: tail is 3; three uops bring it to 6, then A,B,C wrap.
        q.bundle_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            x = mk(MIOP_ADDI, 32'h500 + 32'(4 * i));
            exp_q.push_back(x);
            q.bundle_miinst[i] = x;
        end
        q.bundle_miinst[3] = nop;
        tick();
        a = mk(MIOP_LOAD, 32'h600);
        b = mk(MIOP_STORE, 32'h604);
        c = mk(MIOP_JR, 32'h608);
        exp_q.push_back(a); exp_q.push_back(b); exp_q.push_back(c);
        q.bundle_miinst = bun(a, b, nop, c);
        tick();
        q.bundle_valid = 1'b0;
        chk("t3_count", 64'(q.count), 6);
        q.issue_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        q.issue_ready = 1'b0;
        chk("t3_drained", 64'(q.count), 0);

        // Same-cycle push of two and pop at count=3.
        q.bundle_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            x = mk(MIOP_STORE, 32'h700 + 32'(4 * i));
            exp_q.push_back(x);
            q.bundle_miinst[i] = x;
        end
        q.bundle_miinst[3] = nop;
        tick();
        chk("t4_count3", 64'(q.count), 3);
        a = mk(MIOP_ADDI, 32'h800);
        b = mk(MIOP_J, 32'h804);
        exp_q.push_back(a); exp_q.push_back(b);
        q.bundle_miinst = bun(nop, a, nop, b);
        q.issue_ready   = 1'b1;
        tick();
        q.bundle_valid = 1'b0;
        chk("t4_count4", 64'(q.count), 4);
        for (int i = 0; i < 4; i++) tick();
        q.issue_ready = 1'b0;
        chk("t4_drained", 64'(q.count), 0);

        // Flush at count=5 with a bundle and issue_ready both asserted.
        q.bundle_valid = 1'b1;
        for (int i = 0; i < 4; i++) q.bundle_miinst[i] = mk(MIOP_LOAD, 32'h900 + 32'(4 * i));
        tick();
        q.bundle_miinst = bun(mk(MIOP_ADDI, 32'h910), nop, nop, nop);
        tick();
        chk("t5_count5", 64'(q.count), 5);
        exp_q.delete();
        q.bundle_miinst = bun(mk(MIOP_JR, 32'hA00), mk(MIOP_JR, 32'hA04), nop, nop);
        q.issue_ready   = 1'b1;
        q.flush         = 1'b1;
        tick();
        q.flush        = 1'b0;
        q.bundle_valid = 1'b0;
        q.issue_ready  = 1'b0;
        chk("t5_count0", 64'(q.count), 0);
        chk("t5_issue_valid", 64'(q.issue_valid), 0);
        chk("t5_empty", 64'(q.empty), 1);
        a = mk(MIOP_STORE, 32'hA40);
        exp_q.push_back(a);
        q.bundle_miinst = bun(nop, nop, a, nop);
        q.bundle_valid  = 1'b1;
        tick();
        q.bundle_valid = 1'b0;
        chk("t5_after_count", 64'(q.count), 1);
        q.issue_ready = 1'b1;
        tick();
        q.issue_ready = 1'b0;
        chk("t5_after_drain", 64'(q.count), 0);

        // All-NOP bundle, then a JMP bundle.
        q.bundle_miinst = bun(nop, nop, nop, nop);
        q.bundle_valid  = 1'b1;
        tick();
        chk("t6_nop_count", 64'(q.count), 0);
        chk("t6_nop_empty", 64'(q.empty), 1);
        a = mk(MIOP_J, 32'hABC);
        exp_q.push_back(a);
        q.bundle_miinst = bun(nop, a, nop, nop);
        tick();
        chk("t6_j_count", 64'(q.count), 1);
        chk("t6_j_op", 64'(q.issue_miinst.op), 64'(MIOP_J));
        chk("t6_j_pc", 64'(q.issue_miinst.pc), 64'h0ABC);

        // Fill to 7, then reset mid-handshake.
        q.bundle_miinst = bun(mk(MIOP_ADDI, 32'hB00), mk(MIOP_ADDI, 32'hB04), mk(MIOP_ADDI, 32'hB08), nop);
        tick();
        q.bundle_miinst = bun(nop, mk(MIOP_LOAD, 32'hB10), mk(MIOP_LOAD, 32'hB14), mk(MIOP_LOAD, 32'hB18));
        tick();
        chk("t7_count7", 64'(q.count), 7);
        exp_q.delete();
        q.bundle_miinst = bun(mk(MIOP_JR, 32'hC00), nop, nop, nop);
        q.issue_ready   = 1'b1;
        rstn            = 1'b0;
        tick();
        rstn           = 1'b1;
        q.bundle_valid = 1'b0;
        q.issue_ready  = 1'b0;
        chk("t7_count0", 64'(q.count), 0);
        chk("t7_issue_valid", 64'(q.issue_valid), 0);
        chk("t7_empty", 64'(q.empty), 1);
        chk("t7_ready", 64'(q.bundle_ready), 1);
        a = mk(MIOP_LOAD, 32'hD00);
        exp_q.push_back(a);
        q.bundle_miinst = bun(a, nop, nop, nop);
        q.bundle_valid  = 1'b1;
        tick();
        q.bundle_valid = 1'b0;
        q.issue_ready  = 1'b1;
        tick();
        q.issue_ready = 1'b0;
        chk("t7_final_count", 64'(q.count), 0);
        chk("scoreboard_left", 64'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
